final_out_deser: RTL and testbench
==================================

# final_out_deser

Receive-side collector for the serial result stream of the Final datapath. It samples the 1-bit `OUT` qualified by `OUT_VALID`, packs each contiguous burst into `WIDTH`-bit words (first bit received = MSB), and marks the burst's last word. It also reports the burst length in bits. It sits downstream of the Final block and hands packed words to the checker or host side.

## Interface
- `WIDTH`, 8, word width in bits; must be at least 2.
- `CNT_W`, 4, width of `WORD_BITS`; must satisfy `WIDTH < 2**CNT_W`.
- `LEN_W`, 10, width of the burst-length counter.

Ports:
- `CLK`  in  1  single clock; all state is updated on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `OUT_VALID`  in  1  burst qualifier from the Final block; high means `OUT` carries a valid bit.
- `OUT`  in  1  serial data bit.
- `WORD_VALID`  out  1  one-cycle pulse: `WORD`, `WORD_BITS` and `WORD_LAST` are new.
- `WORD`  out  WIDTH  packed word; a partial word is left-aligned and its unused LSBs are 0.
- `WORD_BITS`  out  CNT_W  number of valid bits in `WORD`, from 1 to `WIDTH`.
- `WORD_LAST`  out  1  `WORD` is the final word of its burst.
- `BURST_DONE`  out  1  one-cycle pulse, coincident with the `WORD_VALID` that carries `WORD_LAST`=1.
- `BURST_LEN`  out  LEN_W  bit count of the most recently completed burst; held until the next `BURST_DONE`.
- `OVERFLOW`  out  1  the completed burst exceeded `2**LEN_W-1` bits; updated and held together with `BURST_LEN`.

## Operation
- A burst is a maximal run of cycles with `OUT_VALID`=1. A sample with `OUT_VALID`=0 ends the burst. There are no gaps inside a burst.
- FSM states:
  - IDLE: waits for a burst.
  - COLLECT: a burst is in progress.
- Transitions:
  - IDLE → COLLECT: on an edge with `OUT_VALID`=1. That bit is accepted and the length counter is set to 1.
  - COLLECT → COLLECT: on an edge with `OUT_VALID`=1.
  - COLLECT → IDLE: on an edge with `OUT_VALID`=0.
- Accepting a bit:
  - The bit is shifted into the shift register at the LSB, and the bit counter `cnt` increments.
  - The length counter increments and saturates at `2**LEN_W-1`. A sticky overflow flag sets on any attempted increment past saturation.
- When `cnt` reaches `WIDTH`, the shift register moves into the staging register (marked full) and `cnt` clears.
- A full staging register is released, with `WORD_LAST`=0 and `WORD_BITS`=`WIDTH`, on the next accepted bit. This holdback is what makes it possible to mark the last word correctly. Staging full always implies `cnt`=0.
- On the burst-ending edge (state COLLECT, `OUT_VALID`=0):
  - If staging is full: emit the staged word with `WORD_LAST`=1 and `WORD_BITS`=`WIDTH`.
  - Otherwise: emit the shift register shifted left by `WIDTH-cnt`, with `WORD_LAST`=1 and `WORD_BITS`=`cnt`.
  - In both cases: pulse `BURST_DONE`, load `BURST_LEN` and `OVERFLOW`, clear all internal counters and flags, and go to IDLE.
- A one-cycle `OUT_VALID` low between bursts is legal. IDLE accepts the next burst's first bit on the following edge.
- `WORD`, `WORD_BITS` and `WORD_LAST` hold their last value while `WORD_VALID`=0.

## Timing
- All outputs are registered. The pulses `WORD_VALID` and `BURST_DONE` are high for exactly one cycle.
- Reset values: every output is 0 and the FSM is in IDLE. Shift register, staging register, counters and flags are all cleared.
- Latency:
  - A non-last full word appears on the outputs immediately after the edge that accepts the first bit of the following word.
  - The last word appears immediately after the burst-ending edge, i.e. one cycle after its final bit.
- Reset asserted mid-burst discards all partial state. No word and no `BURST_DONE` is produced for that burst, and `BURST_LEN` reads 0.
- If `OUT_VALID`=1 at the first edge after `RST` deasserts, that bit starts a new burst.
- Throughput: one bit per cycle sustained, with no backpressure.

## Test plan
- **Single short burst:** reset, then 3 bits 1,0,1 followed by `OUT_VALID`=0 → one `WORD_VALID` with `WORD`=0xA0, `WORD_BITS`=3, `WORD_LAST`=1, `BURST_DONE`=1, `BURST_LEN`=3.
- **Exact-word burst:** 8 bits 10110011 → nothing emitted until the ending edge, then `WORD`=0xB3, `WORD_BITS`=8, `WORD_LAST`=1, `BURST_LEN`=8.
- **Multi-word burst:** 11 bits 10110011 101 →
  - 0xB3 with `WORD_LAST`=0, pulsing right after the 9th bit's edge;
  - then 0xA0 with `WORD_BITS`=3, `WORD_LAST`=1, `BURST_LEN`=11.
- **Back-to-back bursts:** 16 bits, 1 idle cycle, 1 bit (value 1) →
  - words with `WORD_LAST` sequence 0,1;
  - then 0x80 with `WORD_BITS`=1;
  - two `BURST_DONE` pulses, with `BURST_LEN` 16 then 1.
- **Saturation:** with `LEN_W`=4, a 20-bit burst → `BURST_LEN`=15, `OVERFLOW`=1. The next 2-bit burst → `BURST_LEN`=2, `OVERFLOW`=0.
- **Reset mid-burst:** pulse `RST` after 5 bits of a burst, then a fresh 8-bit burst → no output for the aborted burst; exactly one word with `BURST_LEN`=8.

Source files
------------

// File: rtl/final_out_deser.sv
// Collects the Final block's serial result stream into WIDTH-bit words, MSB first,
// flagging the last word of each burst and reporting the burst length in bits.
module final_out_deser #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4,
   parameter int unsigned LEN_W = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             OUT_VALID,
   input  logic             OUT,
   output logic             WORD_VALID,
   output logic [WIDTH-1:0] WORD,
   output logic [CNT_W-1:0] WORD_BITS,
   output logic             WORD_LAST,
   output logic             BURST_DONE,
   output logic [LEN_W-1:0] BURST_LEN,
   output logic             OVERFLOW
);

   typedef enum logic [0:0] {st_idle, st_collect} state_e;

   localparam logic [CNT_W-1:0] full_cnt = CNT_W'(WIDTH);
   localparam logic [LEN_W-1:0] len_max  = {LEN_W{1'b1}};

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   stage_q, stage_d;
   logic               stage_full_q, stage_full_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovf_q, ovf_d;

   logic               word_valid_q, word_valid_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic [CNT_W-1:0]   word_bits_q, word_bits_d;
   logic               word_last_q, word_last_d;
   logic               burst_done_q, burst_done_d;
   logic [LEN_W-1:0]   burst_len_q, burst_len_d;
   logic               overflow_q, overflow_d;

   logic [WIDTH-1:0]   sreg_shift;
   logic [CNT_W-1:0]   cnt_inc;
   logic [CNT_W-1:0]   shamt;

   assign sreg_shift = {sreg_q[WIDTH-2:0], OUT};
   assign cnt_inc    = cnt_q + 1'b1;
   assign shamt      = full_cnt - cnt_q;

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      cnt_d        = cnt_q;
      stage_d      = stage_q;
      stage_full_d = stage_full_q;
      len_d        = len_q;
      ovf_d        = ovf_q;
      word_valid_d = 1'b0;
      word_d       = word_q;
      word_bits_d  = word_bits_q;
      word_last_d  = word_last_q;
      burst_done_d = 1'b0;
      burst_len_d  = burst_len_q;
      overflow_d   = overflow_q;

      unique case (state_q)
         st_idle: begin
            if (OUT_VALID) begin
               state_d      = st_collect;
               sreg_d       = {{(WIDTH-1){1'b0}}, OUT};
               cnt_d        = CNT_W'(1);
               stage_full_d = 1'b0;
               len_d        = LEN_W'(1);
               ovf_d        = 1'b0;
            end
         end
         st_collect: begin
            if (OUT_VALID) begin
               // The staged word is only known to be non-last once another bit arrives.
               if (stage_full_q) begin
                  word_valid_d = 1'b1;
                  word_d       = stage_q;
                  word_bits_d  = full_cnt;
                  word_last_d  = 1'b0;
                  stage_full_d = 1'b0;
               end
               sreg_d = sreg_shift;
               if (cnt_inc == full_cnt) begin
                  stage_d      = sreg_shift;
                  stage_full_d = 1'b1;
                  cnt_d        = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
               if (len_q == len_max) ovf_d = 1'b1;
               else                  len_d = len_q + 1'b1;
            end else begin
               word_valid_d = 1'b1;
               word_last_d  = 1'b1;
               if (stage_full_q) begin
                  word_d      = stage_q;
                  word_bits_d = full_cnt;
               end else begin
                  word_d      = sreg_q << shamt;
                  word_bits_d = cnt_q;
               end
               burst_done_d = 1'b1;
               burst_len_d  = len_q;
               overflow_d   = ovf_q;
               sreg_d       = '0;
               cnt_d        = '0;
               stage_d      = '0;
               stage_full_d = 1'b0;
               len_d        = '0;
               ovf_d        = 1'b0;
               state_d      = st_idle;
            end
         end
         default: state_d = st_idle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= st_idle;
         sreg_q       <= '0;
         cnt_q        <= '0;
         stage_q      <= '0;
         stage_full_q <= 1'b0;
         len_q        <= '0;
         ovf_q        <= 1'b0;
         word_valid_q <= 1'b0;
         word_q       <= '0;
         word_bits_q  <= '0;
         word_last_q  <= 1'b0;
         burst_done_q <= 1'b0;
         burst_len_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         cnt_q        <= cnt_d;
         stage_q      <= stage_d;
         stage_full_q <= stage_full_d;
         len_q        <= len_d;
         ovf_q        <= ovf_d;
         word_valid_q <= word_valid_d;
         word_q       <= word_d;
         word_bits_q  <= word_bits_d;
         word_last_q  <= word_last_d;
         burst_done_q <= burst_done_d;
         burst_len_q  <= burst_len_d;
         overflow_q   <= overflow_d;
      end
   end

   assign WORD_VALID = word_valid_q;
   assign WORD       = word_q;
   assign WORD_BITS  = word_bits_q;
   assign WORD_LAST  = word_last_q;
   assign BURST_DONE = burst_done_q;
   assign BURST_LEN  = burst_len_q;
   assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_final_out_deser.sv
// Scoreboard bench for final_out_deser: directed bursts push expected words, a negedge
// monitor pops and compares; a LEN_W=4 copy sees the same stream for saturation.
module tb_final_out_deser;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       OUT_VALID = 1'b0;
   logic       OUT = 1'b0;

   logic       wv, wl, bd, ov;
   logic [7:0] w;
   logic [3:0] wb;
   logic [9:0] bl;

   logic       wv4, wl4, bd4, ov4;
   logic [7:0] w4;
   logic [3:0] wb4;
   logic [3:0] bl4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] word;
      int         bits;
      logic       last;
      int         len;
      logic       ovf;
      int         len4;
      logic       ovf4;
   } exp_t;

   exp_t q[$];

   always #5 CLK = ~CLK;

   final_out_deser #(.WIDTH(8), .CNT_W(4), .LEN_W(10)) dut (
      .CLK(CLK), .RST(RST), .OUT_VALID(OUT_VALID), .OUT(OUT),
      .WORD_VALID(wv), .WORD(w), .WORD_BITS(wb), .WORD_LAST(wl),
      .BURST_DONE(bd), .BURST_LEN(bl), .OVERFLOW(ov)
   );

   final_out_deser #(.WIDTH(8), .CNT_W(4), .LEN_W(4)) dut4 (
      .CLK(CLK), .RST(RST), .OUT_VALID(OUT_VALID), .OUT(OUT),
      .WORD_VALID(wv4), .WORD(w4), .WORD_BITS(wb4), .WORD_LAST(wl4),
      .BURST_DONE(bd4), .BURST_LEN(bl4), .OVERFLOW(ov4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push(input logic [7:0] word, input int bits, input logic last,
                                input int len, input logic ovf, input int len4,
                                input logic ovf4);
      exp_t e;
      e.word = word; e.bits = bits; e.last = last;
      e.len = len; e.ovf = ovf; e.len4 = len4; e.ovf4 = ovf4;
      q.push_back(e);
   endfunction

   task automatic send(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         OUT_VALID = 1'b1;
         OUT       = bits[i];
         @(posedge CLK); #1;
      end
      OUT_VALID = 1'b0;
      OUT       = 1'b0;
   endtask

   task automatic idle(input int n);
      OUT_VALID = 1'b0;
      OUT       = 1'b0;
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   // Monitor: every word pulse from either instance must match the queue head.
   always @(negedge CLK) begin
      if (!RST && (wv || wv4)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got word 0x%0h, expected no word at %0t", w, $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("word_valid", 32'(wv), 32'd1);
            chk("word4_valid", 32'(wv4), 32'd1);
            chk("word", 32'(w), 32'(e.word));
            chk("word_bits", 32'(wb), 32'(e.bits));
            chk("word_last", 32'(wl), 32'(e.last));
            chk("burst_done", 32'(bd), 32'(e.last));
            chk("word4", 32'(w4), 32'(e.word));
            if (e.last) begin
               chk("burst_len", 32'(bl), 32'(e.len));
               chk("overflow", 32'(ov), 32'(e.ovf));
               chk("burst_len4", 32'(bl4), 32'(e.len4));
               chk("overflow4", 32'(ov4), 32'(e.ovf4));
            end
         end
      end else if (!RST && (bd || bd4)) begin
         checks++;
         errors++;
         $display("FAIL stray_burst_done: got 1, expected 0 at %0t", $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("rst_word_valid", 32'(wv), 32'd0);
      chk("rst_word", 32'(w), 32'd0);
      chk("rst_word_bits", 32'(wb), 32'd0);
      chk("rst_word_last", 32'(wl), 32'd0);
      chk("rst_burst_done", 32'(bd), 32'd0);
      chk("rst_burst_len", 32'(bl), 32'd0);
      chk("rst_overflow", 32'(ov), 32'd0);

      // Short burst 1,0,1
      push(8'hA0, 3, 1'b1, 3, 1'b0, 3, 1'b0);
      send(32'b101, 3);
      idle(2);

      // Exact single word
      push(8'hB3, 8, 1'b1, 8, 1'b0, 8, 1'b0);
      send(32'hB3, 8);
      idle(2);

      // Two words: 10110011 101
      push(8'hB3, 8, 1'b0, 0, 1'b0, 0, 1'b0);
      push(8'hA0, 3, 1'b1, 11, 1'b0, 11, 1'b0);
      send(32'h59D, 11);
      idle(2);

      // Back-to-back with a single idle cycle between; 16 bits saturate the LEN_W=4 copy
      push(8'hB3, 8, 1'b0, 0, 1'b0, 0, 1'b0);
      push(8'hC5, 8, 1'b1, 16, 1'b0, 15, 1'b1);
      push(8'h80, 1, 1'b1, 1, 1'b0, 1, 1'b0);
      send(32'hB3C5, 16);
      idle(1);
      send(32'b1, 1);
      idle(2);

      // 20-bit burst then a 2-bit burst
      push(8'hAB, 8, 1'b0, 0, 1'b0, 0, 1'b0);
      push(8'hCD, 8, 1'b0, 0, 1'b0, 0, 1'b0);
      push(8'hE0, 4, 1'b1, 20, 1'b0, 15, 1'b1);
      push(8'hC0, 2, 1'b1, 2, 1'b0, 2, 1'b0);
      send(32'hABCDE, 20);
      idle(1);
      send(32'b11, 2);
      idle(2);

      // Reset after 5 bits: that burst vanishes
      send(32'b10101, 5);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("abort_burst_len", 32'(bl), 32'd0);
      chk("abort_burst_len4", 32'(bl4), 32'd0);
      chk("abort_overflow4", 32'(ov4), 32'd0);
      chk("abort_word_valid", 32'(wv), 32'd0);
      @(posedge CLK); #1;
      push(8'h5A, 8, 1'b1, 8, 1'b0, 8, 1'b0);
      send(32'h5A, 8);
      idle(4);

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
